// File: rtl/envelope_bank.sv
// ============================================================================
//  Module      : envelope_bank
//  Description : Bank of NVOICES ADSR envelope generators. They share one
//                update datapath that visits the voices in order, one voice
//                per clock, after each sample_tick.
//  Options     : ENVBANK_EXP_RELEASE_EN - exponential-shaped release
//                (decrement = release rate + acc>>8); linear when undefined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module envelope_bank #(
    parameter int NVOICES          = 4,
    parameter int BITSIZE          = 16,
    parameter int ACCUMULATOR_BITS = 26,
    parameter int SAMPLE_CLK_FREQ  = 44100
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              sample_tick,
    input  logic [NVOICES-1:0]                                gate,
    input  logic [4*NVOICES-1:0]                              a,
    input  logic [4*NVOICES-1:0]                              d,
    input  logic [4*NVOICES-1:0]                              s,
    input  logic [4*NVOICES-1:0]                              r,
    output logic signed [BITSIZE-1:0]                         amplitude,
    output logic                                              amp_valid,
    output logic [((NVOICES > 1) ? $clog2(NVOICES) : 1)-1:0]  amp_voice,
    output logic                                              busy,
    output logic                                              overrun
);

    localparam int AB = ACCUMULATOR_BITS;
    localparam int VW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam int IW = $clog2(NVOICES + 1);
    localparam logic [AB-1:0] C_ACC_MAX = {AB{1'b1}};

    // Increment per update for a segment duration in milliseconds.
    // floor(2^AB*1000/(t_ms*Fs)) equals floor(2^AB/(t*Fs)) exactly.
    function automatic logic [AB-1:0] rate_inc(input int code);
        logic [63:0] t_ms;
        logic [63:0] q;
        case (code)
            0:       t_ms = 64'd2;
            1:       t_ms = 64'd8;
            2:       t_ms = 64'd16;
            3:       t_ms = 64'd24;
            4:       t_ms = 64'd38;
            5:       t_ms = 64'd56;
            6:       t_ms = 64'd68;
            7:       t_ms = 64'd80;
            8:       t_ms = 64'd100;
            9:       t_ms = 64'd250;
            10:      t_ms = 64'd500;
            11:      t_ms = 64'd800;
            12:      t_ms = 64'd1000;
            13:      t_ms = 64'd3000;
            14:      t_ms = 64'd5000;
            default: t_ms = 64'd8000;
        endcase
        q = ((64'd1 << AB) * 64'd1000) / (t_ms * 64'(SAMPLE_CLK_FREQ));
        return q[AB-1:0];
    endfunction

    localparam logic [AB-1:0] C_RATE_INC [16] = '{
        rate_inc(0),  rate_inc(1),  rate_inc(2),  rate_inc(3),
        rate_inc(4),  rate_inc(5),  rate_inc(6),  rate_inc(7),
        rate_inc(8),  rate_inc(9),  rate_inc(10), rate_inc(11),
        rate_inc(12), rate_inc(13), rate_inc(14), rate_inc(15)
    };

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // Per-voice state
    state_e        state_q [NVOICES];
    logic [AB-1:0] acc_q   [NVOICES];
    logic          lgate_q [NVOICES];

    // Pass sequencing and output registers
    logic               busy_q;
    logic [IW-1:0]      idx_q;
    logic [BITSIZE-1:0] amp_q;
    logic               valid_q;
    logic [VW-1:0]      voice_q;
    logic               overrun_q;

    // Shared update datapath
    logic          w_start;
    logic          w_do;
    logic [VW-1:0] w_vidx;
    int            w_base;
    state_e        w_cur_state;
    logic [AB-1:0] w_cur_acc;
    logic          w_gate;
    logic          w_lgate;
    logic [AB-1:0] w_att_inc;
    logic [AB-1:0] w_dec_inc;
    logic [AB-1:0] w_level;
    logic [AB:0]   w_att_sum;
    logic [AB:0]   w_rel_dec;
    state_e        state_d;
    logic [AB-1:0] acc_d;

    // The tick cycle itself updates voice 0 so its result appears one cycle later.
    assign w_start = sample_tick && !busy_q;
    assign w_do    = w_start || (busy_q && (idx_q != IW'(NVOICES)));
    assign w_vidx  = w_start ? '0 : idx_q[VW-1:0];

    // Next state and accumulator for the voice being visited this cycle.
    always_comb begin
        w_base      = 4 * int'(w_vidx);
        w_cur_state = state_q[w_vidx];
        w_cur_acc   = acc_q[w_vidx];
        w_gate      = gate[w_vidx];
        w_lgate     = lgate_q[w_vidx];
        w_att_inc   = C_RATE_INC[a[w_base +: 4]];
        w_dec_inc   = C_RATE_INC[d[w_base +: 4]];
        w_level     = {s[w_base +: 4], {(AB-4){1'b1}}};
        w_att_sum   = {1'b0, w_cur_acc} + {1'b0, w_att_inc};
`ifdef ENVBANK_EXP_RELEASE_EN
        w_rel_dec   = {1'b0, C_RATE_INC[r[w_base +: 4]]} + {1'b0, (w_cur_acc >> 8)};
`else
        w_rel_dec   = {1'b0, C_RATE_INC[r[w_base +: 4]]};
`endif
        state_d     = w_cur_state;
        acc_d       = w_cur_acc;

        // Attack step shared by gate-on and ongoing attack; starts from the
        // current level so a retrigger never drops the output.
        if ((w_gate && !w_lgate) || (w_cur_state == ST_ATTACK && w_gate)) begin
            if (w_att_sum >= {1'b0, C_ACC_MAX}) begin
                acc_d   = C_ACC_MAX;
                state_d = ST_DECAY;
            end else begin
                acc_d   = w_att_sum[AB-1:0];
                state_d = ST_ATTACK;
            end
        end else begin
            case (w_cur_state)
                ST_OFF: begin
                    acc_d = '0;
                end
                ST_ATTACK: begin
                    state_d = ST_RELEASE;
                end
                ST_DECAY: begin
                    if (!w_gate) begin
                        state_d = ST_RELEASE;
                    end else if (w_cur_acc <= w_level) begin
                        state_d = ST_SUSTAIN;
                    end else if ((w_cur_acc - w_level) <= w_dec_inc) begin
                        acc_d   = w_level;
                        state_d = ST_SUSTAIN;
                    end else begin
                        acc_d = w_cur_acc - w_dec_inc;
                    end
                end
                ST_SUSTAIN: begin
                    if (!w_gate) begin
                        state_d = ST_RELEASE;
                    end else begin
                        acc_d = w_level;
                    end
                end
                ST_RELEASE: begin
                    if (w_rel_dec >= {1'b0, w_cur_acc}) begin
                        acc_d   = '0;
                        state_d = ST_OFF;
                    end else begin
                        acc_d = w_cur_acc - w_rel_dec[AB-1:0];
                    end
                end
                default: begin
                    acc_d   = '0;
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // Commit the visited voice's new state, level and gate history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NVOICES; k++) begin
                state_q[k] <= ST_OFF;
                acc_q[k]   <= '0;
                lgate_q[k] <= 1'b0;
            end
        end else if (w_do) begin
            state_q[w_vidx] <= state_d;
            acc_q[w_vidx]   <= acc_d;
            lgate_q[w_vidx] <= w_gate;
        end
    end

    // Pass sequencing, result registers and overrun detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            idx_q     <= '0;
            amp_q     <= '0;
            valid_q   <= 1'b0;
            voice_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= w_do;
            overrun_q <= sample_tick && busy_q;
            if (w_do) begin
                amp_q   <= {1'b0, acc_d[AB-1 -: BITSIZE-1]};
                voice_q <= w_vidx;
            end
            if (w_start) begin
                busy_q <= 1'b1;
                idx_q  <= IW'(1);
            end else if (busy_q) begin
                if (idx_q == IW'(NVOICES)) begin
                    busy_q <= 1'b0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign amplitude = amp_q;
    assign amp_valid = valid_q;
    assign amp_voice = voice_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire
